bist_stim_resp_ctrl: RTL and testbench

- Sequential self-test controller for the team's mapped combinational netlists, for example a 14-input / 8-output benchmark.
- Pattern side: generates pseudo-random input vectors with a 14-bit LFSR and drives them onto the netlist inputs.
- Response side: reads the netlist outputs back and compacts them into an 8-bit MISR signature.
- Sits between the netlist under test and a host that issues start and compares the signature against a golden value.

---
 rtl/bist_stim_resp_ctrl.sv | 145 ++++++++++++++
 tb/tb_bist_stim_resp_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bist_stim_resp_ctrl.sv
// BIST stimulus/response controller.
// Drives LFSR patterns into a combinational netlist under test, compacts the
// returned responses into a MISR signature and compares it against a golden value.
module bist_stim_resp_ctrl #(
    parameter int               PAT_W     = 14,
    parameter int               RSP_W     = 8,
    parameter int               CNT_W     = 16,
    parameter logic [PAT_W-1:0] LFSR_SEED = 14'h0001,
    parameter logic [PAT_W-1:0] LFSR_TAPS = 14'h3802,
    parameter logic [RSP_W-1:0] MISR_POLY = 8'h1D,
    parameter int               RSP_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [RSP_W-1:0] golden_i,
    output logic [PAT_W-1:0] pat_o,
    output logic             pat_valid_o,
    input  logic [RSP_W-1:0] rsp_i,
    output logic             busy,
    output logic             done,
    output logic [RSP_W-1:0] signature,
    output logic             pass
);

    // An all-zero seed locks the LFSR; latency beyond 3 is unsupported.
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("bist_stim_resp_ctrl: LFSR_SEED must be nonzero");
    end
    if (RSP_LAT < 0 || RSP_LAT > 3) begin : g_bad_lat
        $error("bist_stim_resp_ctrl: RSP_LAT must be in 0..3");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] lfsr;
    logic [RSP_W-1:0] misr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       drain_cnt;
    logic [RSP_W-1:0] sig_q;
    logic             pass_q;
    logic             cap_valid;
    logic             launch;
    logic [PAT_W-1:0] lfsr_nxt;
    logic [RSP_W-1:0] misr_nxt;

    // A run launches only from IDLE; abort overrides a simultaneous start.
    assign launch   = (state == S_IDLE) && start && !abort;
    assign lfsr_nxt = {lfsr[PAT_W-2:0], ^(lfsr & LFSR_TAPS)};
    assign misr_nxt = {misr[RSP_W-2:0], 1'b0}
                    ^ (misr[RSP_W-1] ? MISR_POLY : '0)
                    ^ rsp_i;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (launch) state_nxt = (num_pat == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (cnt <= CNT_W'(1))
                    state_nxt = (RSP_LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                state_nxt = S_IDLE;
                else if (drain_cnt == '0) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pattern generator, pattern/drain counters, MISR and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            misr      <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
            sig_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            if (cap_valid) misr <= misr_nxt;
            if (launch) begin
                lfsr <= LFSR_SEED;
                misr <= '0;
                cnt  <= num_pat;
            end
            if (state == S_RUN) begin
                lfsr      <= lfsr_nxt;
                drain_cnt <= 2'(RSP_LAT - 1);
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            if (state == S_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 2'd1;
            if (state == S_DONE && !abort) begin
                sig_q  <= misr;
                pass_q <= (misr == golden_i);
            end
        end
    end

    // Response capture strobe: pattern valid delayed by the netlist latency.
    if (RSP_LAT == 0) begin : g_lat0
        assign cap_valid = pat_valid_o;
    end else begin : g_latn
        logic [RSP_LAT-1:0] vld_sr;

        // Valid delay line; abort discards any captures still in flight.
        always_ff @(posedge clk) begin
            if (rst || abort) begin
                vld_sr <= '0;
            end else begin
                vld_sr[0] <= pat_valid_o;
                for (int i = 1; i < RSP_LAT; i++) vld_sr[i] <= vld_sr[i-1];
            end
        end
        assign cap_valid = vld_sr[RSP_LAT-1];
    end

    // Outputs: the result is shown live in the DONE cycle and held afterwards.
    assign pat_valid_o = (state == S_RUN);
    assign pat_o       = pat_valid_o ? lfsr : '0;
    assign busy        = (state == S_RUN) || (state == S_DRAIN);
    assign done        = (state == S_DONE) && !abort;
    assign signature   = done ? misr : sig_q;
    assign pass        = done ? (misr == golden_i) : pass_q;

endmodule

// File: tb/tb_bist_stim_resp_ctrl.sv
// Self-checking bench for bist_stim_resp_ctrl. Two instances (response latency
// 1 and 0) share stimulus; a behavioural model predicts patterns, timing and
// signatures from the rules of the block.
module tb_bist_stim_resp_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] num_pat;
    logic [7:0]  golden_i, rsp_i;
    logic [13:0] pat_o     [2];
    logic        pat_valid [2];
    logic        busy      [2];
    logic        done      [2];
    logic [7:0]  signature [2];
    logic        pass      [2];

    always #5 clk = ~clk;

    bist_stim_resp_ctrl #(.RSP_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pat(num_pat),
        .golden_i(golden_i), .pat_o(pat_o[0]), .pat_valid_o(pat_valid[0]),
        .rsp_i(rsp_i), .busy(busy[0]), .done(done[0]),
        .signature(signature[0]), .pass(pass[0])
    );

    bist_stim_resp_ctrl #(.RSP_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pat(num_pat),
        .golden_i(golden_i), .pat_o(pat_o[1]), .pat_valid_o(pat_valid[1]),
        .rsp_i(rsp_i), .busy(busy[1]), .done(done[1]),
        .signature(signature[1]), .pass(pass[1])
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  rsp_arr  [256];
    logic [7:0]  gold_arr [256];
    logic [7:0]  prev_sig [2];
    logic        prev_pass[2];
    logic [13:0] first_pats[5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Fibonacci LFSR step: feedback from bits 13, 12, 11 and 1.
    function automatic logic [13:0] lfsr_step(input logic [13:0] s);
        return {s[12:0], s[13] ^ s[12] ^ s[11] ^ s[1]};
    endfunction

    // Signature of responses offered in cycles first..last (polynomial 0x1D).
    function automatic logic [7:0] misr_fold(input int first, input int last);
        logic [7:0] m = 8'h00;
        for (int i = first; i <= last; i++) begin
            logic msb = m[7];
            m = {m[6:0], 1'b0};
            if (msb) m = m ^ 8'h1D;
            m = m ^ rsp_arr[i];
        end
        return m;
    endfunction

    // One run starting at cycle 0 with start=1. gmode: 0 golden matches,
    // 1 golden off by one bit, 2 random golden. abort_at/rst_at kill the run.
    task automatic run(input int n, input bit rsp_const, input logic [7:0] rsp_val,
                       input int gmode, input int abort_at, input int rst_at);
        int          kill, last;
        int          d[2];
        logic [7:0]  expv[2];
        logic        expp[2];
        logic [13:0] pat;
        bit          killed, exp_valid;
        kill = (abort_at > 0) ? abort_at : rst_at;
        for (int c = 0; c < 256; c++) begin
            rsp_arr[c]  = rsp_const ? rsp_val : 8'($urandom);
            gold_arr[c] = 8'($urandom);
        end
        for (int l = 0; l < 2; l++) begin
            d[l]    = (n == 0) ? 1 : n + l + 1;
            expv[l] = (n == 0) ? 8'h00 : misr_fold(1 + l, n + l);
            gold_arr[d[l]] = (gmode == 0) ? expv[l] :
                             (gmode == 1) ? (expv[l] ^ 8'h01) : 8'($urandom);
        end
        for (int l = 0; l < 2; l++) expp[l] = (gold_arr[d[l]] == expv[l]);
        last = (kill > 0) ? kill + 3 : d[1] + 2;
        pat  = 14'h0001;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            if (c == 0) start = 1'b1;
            else if (c <= d[0] && (kill == 0 || c <= kill)) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
            abort    = (abort_at > 0 && c == abort_at);
            rst      = (rst_at > 0 && c == rst_at);
            num_pat  = (c == 0) ? 16'(n) : 16'($urandom);
            rsp_i    = rsp_arr[c];
            golden_i = gold_arr[c];
            @(negedge clk);
            if (c == 0) begin
                check("idle_busy_l0", 32'(busy[0]), 0);
                check("idle_busy_l1", 32'(busy[1]), 0);
                continue;
            end
            killed    = (kill > 0 && c > kill);
            exp_valid = !killed && c <= n;
            for (int l = 0; l < 2; l++) begin
                check($sformatf("valid_l%0d_c%0d", l, c), 32'(pat_valid[l]), 32'(exp_valid));
                check($sformatf("pat_l%0d_c%0d", l, c), 32'(pat_o[l]), exp_valid ? 32'(pat) : 0);
                check($sformatf("busy_l%0d_c%0d", l, c), 32'(busy[l]),
                      32'(!killed && n > 0 && c <= n + l));
                check($sformatf("done_l%0d_c%0d", l, c), 32'(done[l]), 32'(!killed && c == d[l]));
                if (killed) begin
                    check($sformatf("kill_sig_l%0d_c%0d", l, c), 32'(signature[l]),
                          (rst_at > 0) ? 0 : 32'(prev_sig[l]));
                    check($sformatf("kill_pass_l%0d_c%0d", l, c), 32'(pass[l]),
                          (rst_at > 0) ? 0 : 32'(prev_pass[l]));
                end else if (c >= d[l]) begin
                    check($sformatf("sig_l%0d_c%0d", l, c), 32'(signature[l]), 32'(expv[l]));
                    check($sformatf("pass_l%0d_c%0d", l, c), 32'(pass[l]), 32'(expp[l]));
                end
            end
            if (exp_valid && c <= 5) check($sformatf("known_pat_c%0d", c), 32'(pat_o[1]), 32'(first_pats[c-1]));
            if (rsp_const && rsp_val == 8'h01 && n == 3 && c == d[0] && kill == 0)
                check("const_misr_l0", 32'(signature[0]), 32'h07);
            if (c <= n) pat = lfsr_step(pat);
        end
        for (int l = 0; l < 2; l++) begin
            if (rst_at > 0) begin
                prev_sig[l]  = 8'h00;
                prev_pass[l] = 1'b0;
            end else if (abort_at == 0) begin
                prev_sig[l]  = expv[l];
                prev_pass[l] = expp[l];
            end
        end
    endtask

    initial begin
        first_pats = '{14'h0001, 14'h0002, 14'h0005, 14'h000A, 14'h0015};
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_pat = '0; golden_i = '0; rsp_i = '0;
        prev_sig  = '{8'h00, 8'h00};
        prev_pass = '{1'b0, 1'b0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("rst_pat_l%0d", l), 32'(pat_o[l]), 0);
            check($sformatf("rst_valid_l%0d", l), 32'(pat_valid[l]), 0);
            check($sformatf("rst_busy_l%0d", l), 32'(busy[l]), 0);
            check($sformatf("rst_done_l%0d", l), 32'(done[l]), 0);
            check($sformatf("rst_sig_l%0d", l), 32'(signature[l]), 0);
            check($sformatf("rst_pass_l%0d", l), 32'(pass[l]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        run(5, 1'b0, 8'h00, 0, 0, 0);    // known pattern sequence and timing
        run(3, 1'b1, 8'h01, 0, 0, 0);    // constant response, golden matches
        run(3, 1'b1, 8'h01, 1, 0, 0);    // golden 0x06: pass must drop
        run(0, 1'b0, 8'h00, 0, 0, 0);    // zero-length run
        run(10, 1'b0, 8'h00, 2, 3, 0);   // abort at t3
        run(2, 1'b0, 8'h00, 0, 0, 0);    // restart after abort
        run(100, 1'b0, 8'h00, 0, 0, 40); // reset mid-run
        run(4, 1'b0, 8'h00, 0, 0, 0);    // restart after reset

        // Abort together with start in IDLE: nothing may launch.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; num_pat = 16'd0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_done_l0", 32'(done[0]), 0);
        check("abort_start_done_l1", 32'(done[1]), 0);
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; num_pat = 16'd5;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_busy_l0", 32'(busy[0]), 0);
        check("abort_start_busy_l1", 32'(busy[1]), 0);

        for (int r = 0; r < 6; r++)
            run($urandom_range(1, 30), 1'b0, 8'h00, $urandom_range(0, 2), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
